mem_access_unit: RTL and testbench

Multi-cycle load/store unit between the execute stage and the data-memory bus. Accepts one memory op per request and drives a word-aligned req/ack bus with byte enables. Produces the sign/zero-extended load value that feeds the GPR write-back mux memory input. Raises stall while the access is in flight and reports alignment and bus-timeout errors.

---
 rtl/mem_access_unit_if.sv | 21 ++
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Word-aligned req/ack data-memory bus between the load/store unit and memory.
// The master drives the request side; memory answers with ack and read data.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: one memory op per request, byte-enabled word bus,
// sign/zero-extended load result, alignment and bus-timeout error reporting.
module mem_access_unit #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] rdata_q, rdata_d;
  logic        aerr_q, aerr_d;
  logic        berr_q, berr_d;

  logic        in_req;
  logic        is_store;
  logic        start_misaligned;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [3:0]  be_val;
  logic [31:0] wdata_val;

  assign in_req   = (state_q == S_REQ);
  assign is_store = op_q[2] & (op_q[1:0] != 2'b00);

  // Byte ops can never be misaligned; halves need addr[0]=0, words addr[1:0]=0.
  always_comb begin
    start_misaligned = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: start_misaligned = addr[0];
      OP_LW, OP_SW:         start_misaligned = (addr[1:0] != 2'b00);
      default:              start_misaligned = 1'b0;
    endcase
  end

  assign lane_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lane_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  always_comb begin
    load_val = bus.mem_rdata;
    case (op_q)
      OP_LB:   load_val = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_val = {24'h0, lane_byte};
      OP_LH:   load_val = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  load_val = {16'h0, lane_half};
      default: load_val = bus.mem_rdata;
    endcase
  end

  // Lane enables and store data replicated across lanes so memory can pick any.
  always_comb begin
    be_val    = 4'b1111;
    wdata_val = wdata_q;
    case (op_q)
      OP_LB, OP_LBU, OP_SB: be_val = 4'b0001 << addr_q[1:0];
      OP_LH, OP_LHU, OP_SH: be_val = addr_q[1] ? 4'b1100 : 4'b0011;
      default:              be_val = 4'b1111;
    endcase
    case (op_q)
      OP_SB:   wdata_val = {4{wdata_q[7:0]}};
      OP_SH:   wdata_val = {2{wdata_q[15:0]}};
      default: wdata_val = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    aerr_d  = aerr_q;
    berr_d  = berr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          addr_d  = addr;
          wdata_d = wdata;
          wait_d  = 8'd0;
          aerr_d  = 1'b0;
          berr_d  = 1'b0;
          if (start_misaligned) begin
            state_d = S_RESP;
            aerr_d  = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // An ack in the last allowed cycle takes priority over the timeout.
        if (bus.mem_ack) begin
          state_d = S_RESP;
          if (!is_store) rdata_d = load_val;
        end else if (wait_q == 8'(MAX_WAIT - 1)) begin
          state_d = S_RESP;
          berr_d  = 1'b1;
          rdata_d = 32'h0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wait_q  <= 8'd0;
      rdata_q <= 32'h0;
      aerr_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      aerr_q  <= aerr_d;
      berr_q  <= berr_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_RESP);
  assign addr_err = (state_q == S_RESP) & aerr_q;
  assign bus_err  = (state_q == S_RESP) & berr_q;
  assign rdata    = rdata_q;

  assign bus.mem_req   = in_req;
  assign bus.mem_we    = in_req & is_store;
  assign bus.mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_be    = in_req ? be_val : 4'b0000;
  assign bus.mem_wdata = in_req ? wdata_val : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, wait states,
// timeout and mid-request reset, each checked against hand-computed values.
module tb_mem_access_unit;
  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        addr_err;
  logic        bus_err;

  mem_access_unit_if bus ();

  mem_access_unit #(.MAX_WAIT(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .addr_err (addr_err),
    .bus_err  (bus_err),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Observations of the most recent transaction.
  int          req_cnt, done_at, stable_err;
  logic        busy_gap, post_done, post_busy;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic        s_we, s_aerr, s_berr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ack_at: REQ cycle (1-based) on which mem_ack is raised; 0 means never.
  // poke: keep start high with a different op while busy.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input bit poke);
    @(negedge clk);
    start = 1'b1; op = o; addr = a; wdata = wd;
    req_cnt = 0; done_at = 0; stable_err = 0; busy_gap = 1'b0;
    s_addr = 32'h0; s_wdata = 32'h0; s_be = 4'h0; s_we = 1'b0;
    for (int t = 1; t <= 40 && done_at == 0; t++) begin
      @(negedge clk);
      start = poke;
      if (poke) begin op = 3'd7; addr = 32'hFFC; wdata = 32'h0; end
      bus.mem_ack = 1'b0;
      if (!busy) busy_gap = 1'b1;
      if (bus.mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          s_addr = bus.mem_addr; s_be = bus.mem_be; s_wdata = bus.mem_wdata; s_we = bus.mem_we;
        end else if (bus.mem_addr !== s_addr || bus.mem_be !== s_be ||
                     bus.mem_wdata !== s_wdata || bus.mem_we !== s_we) begin
          stable_err++;
        end
        if (req_cnt == ack_at) bus.mem_ack = 1'b1;
      end
      if (done) begin
        done_at = t; s_aerr = addr_err; s_berr = bus_err; s_rdata = rdata;
        start = 1'b0;
      end
    end
    bus.mem_ack = 1'b0;
    start = 1'b0;
    @(negedge clk);
    post_done = done;
    post_busy = busy;
    $display("op=%0d addr=%h req_cycles=%0d done_at=%0d addr_err=%0b bus_err=%0b rdata=%h",
             o, a, req_cnt, done_at, s_aerr, s_berr, s_rdata);
  endtask

  task automatic expect_op(input string tag, input int e_done, input int e_req,
                           input logic [31:0] e_addr, input logic [3:0] e_be, input logic e_we,
                           input logic [31:0] e_wd, input logic e_aerr, input logic e_berr,
                           input logic [31:0] e_rdata);
    check({tag, ".done_at"}, 32'(done_at), 32'(e_done));
    check({tag, ".req_cycles"}, 32'(req_cnt), 32'(e_req));
    if (e_req > 0) begin
      check({tag, ".mem_addr"}, s_addr, e_addr);
      check({tag, ".mem_be"}, {28'h0, s_be}, {28'h0, e_be});
      check({tag, ".mem_we"}, {31'h0, s_we}, {31'h0, e_we});
      if (e_we) check({tag, ".mem_wdata"}, s_wdata, e_wd);
    end
    check({tag, ".addr_err"}, {31'h0, s_aerr}, {31'h0, e_aerr});
    check({tag, ".bus_err"}, {31'h0, s_berr}, {31'h0, e_berr});
    check({tag, ".rdata"}, s_rdata, e_rdata);
    check({tag, ".stable"}, 32'(stable_err), 32'd0);
    check({tag, ".busy_held"}, {31'h0, busy_gap}, 32'd0);
    check({tag, ".single_done"}, {31'h0, post_done}, 32'd0);
    check({tag, ".idle_after"}, {31'h0, post_busy}, 32'd0);
  endtask

  initial begin
    int late_done;
    reset = 1'b1; start = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h80FF7F01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.busy", {31'h0, busy}, 32'd0);
    check("reset.done", {31'h0, done}, 32'd0);
    check("reset.rdata", rdata, 32'h0);
    check("reset.mem_req", {31'h0, bus.mem_req}, 32'd0);
    check("reset.errs", {30'h0, addr_err, bus_err}, 32'd0);
    reset = 1'b0;

    run_op(3'd0, 32'h101, 32'h0, 1, 1'b0);
    expect_op("lb_101", 2, 1, 32'h100, 4'b0010, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000007F);
    run_op(3'd0, 32'h102, 32'h0, 1, 1'b0);
    expect_op("lb_102", 2, 1, 32'h100, 4'b0100, 1'b0, 32'h0, 1'b0, 1'b0, 32'hFFFFFFFF);
    run_op(3'd1, 32'h103, 32'h0, 1, 1'b0);
    expect_op("lbu_103", 2, 1, 32'h100, 4'b1000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h00000080);
    run_op(3'd2, 32'h102, 32'h0, 1, 1'b0);
    expect_op("lh_102", 2, 1, 32'h100, 4'b1100, 1'b0, 32'h0, 1'b0, 1'b0, 32'hFFFF80FF);
    run_op(3'd3, 32'h102, 32'h0, 1, 1'b0);
    expect_op("lhu_102", 2, 1, 32'h100, 4'b1100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h000080FF);
    run_op(3'd4, 32'h100, 32'h0, 1, 1'b0);
    expect_op("lw_100", 2, 1, 32'h100, 4'b1111, 1'b0, 32'h0, 1'b0, 1'b0, 32'h80FF7F01);

    run_op(3'd5, 32'h203, 32'h12345678, 1, 1'b0);
    expect_op("sb_203", 2, 1, 32'h200, 4'b1000, 1'b1, 32'h78787878, 1'b0, 1'b0, 32'h80FF7F01);
    run_op(3'd6, 32'h202, 32'hAAAABEEF, 1, 1'b0);
    expect_op("sh_202", 2, 1, 32'h200, 4'b1100, 1'b1, 32'hBEEFBEEF, 1'b0, 1'b0, 32'h80FF7F01);

    run_op(3'd4, 32'h102, 32'h0, 1, 1'b0);
    expect_op("lw_mis", 1, 0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    run_op(3'd6, 32'h301, 32'h1234, 1, 1'b0);
    expect_op("sh_mis", 1, 0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    run_op(3'd3, 32'h100, 32'h0, 4, 1'b1);
    expect_op("lhu_wait3", 5, 4, 32'h100, 4'b0011, 1'b0, 32'h0, 1'b0, 1'b0, 32'h00007F01);

    run_op(3'd4, 32'h104, 32'h0, 0, 1'b0);
    expect_op("lw_timeout", 17, 16, 32'h104, 4'b1111, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    run_op(3'd1, 32'h100, 32'h0, 16, 1'b0);
    expect_op("lbu_ack16", 17, 16, 32'h100, 4'b0001, 1'b0, 32'h0, 1'b0, 1'b0, 32'h00000001);

    // Reset while the request is outstanding.
    @(negedge clk);
    start = 1'b1; op = 3'd4; addr = 32'h100;
    @(negedge clk);
    start = 1'b0;
    check("rst_mid.req_before", {31'h0, bus.mem_req}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid.mem_req", {31'h0, bus.mem_req}, 32'd0);
    check("rst_mid.busy", {31'h0, busy}, 32'd0);
    check("rst_mid.done", {31'h0, done}, 32'd0);
    check("rst_mid.rdata", rdata, 32'h0);
    late_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    check("rst_mid.quiet", 32'(late_done), 32'd0);
    $display("reset mid-request: mem_req=%0b busy=%0b", bus.mem_req, busy);

    run_op(3'd4, 32'h108, 32'h0, 1, 1'b0);
    expect_op("lw_after_rst", 2, 1, 32'h108, 4'b1111, 1'b0, 32'h0, 1'b0, 1'b0, 32'h80FF7F01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
